ddr_frame_wr_sched: RTL

- Upstream burst scheduler for the DDR write controller.
- Watches a show-ahead (FWFT) video pixel FIFO. Each time one full burst of 128-bit words is buffered, it issues a single write command (wr_en/wr_addr/wr_id/wr_len) to the write controller.
- Streams FIFO data on wr_data, one word per wr_ready beat.
- Walks a linear frame buffer in DDR, restarting at the frame base on each vsync.

---
 rtl/ddr_frame_wr_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ddr_frame_wr_sched.sv
// Burst write scheduler: turns a show-ahead pixel FIFO into fixed-length DDR write bursts over a linear frame buffer.
// Optional FRAME_PINGPONG_EN alternates between two frame buffers and exports wr_frame_sel.
module ddr_frame_wr_sched #(
  parameter int         CTRL_ADDR_WIDTH  = 28,
  parameter int         MEM_DQ_WIDTH     = 16,
  parameter int         BURST_LEN        = 16,
  parameter int         BURSTS_PER_FRAME = 7200,
  parameter int         FRAME_BASE       = 0,
  parameter logic [3:0] WR_ID            = 4'd0,
  parameter int         FIFO_CNT_W       = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vsync,
  input  logic [FIFO_CNT_W-1:0]        fifo_rd_cnt,
  input  logic [MEM_DQ_WIDTH*8-1:0]    fifo_rd_data,
  output logic                         fifo_rd_en,
  output logic                         wr_en,
  output logic [CTRL_ADDR_WIDTH-1:0]   wr_addr,
  output logic [3:0]                   wr_id,
  output logic [3:0]                   wr_len,
  input  logic                         wr_ready,
  input  logic                         wr_cmd_done,
  output logic [MEM_DQ_WIDTH*8-1:0]    wr_data,
  output logic                         frame_done,
  output logic                         frame_err,
`ifdef FRAME_PINGPONG_EN
  output logic                         wr_frame_sel,
`endif
  output logic                         busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;

  localparam int BC_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [CTRL_ADDR_WIDTH-1:0] STEP        = CTRL_ADDR_WIDTH'(BURST_LEN * 8);
  localparam logic [CTRL_ADDR_WIDTH-1:0] BASE0       = CTRL_ADDR_WIDTH'(FRAME_BASE);
  localparam logic [3:0]                 LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [BC_W-1:0]            LAST_BURST  = BC_W'(BURSTS_PER_FRAME - 1);
  localparam logic [FIFO_CNT_W-1:0]      BURST_WORDS = FIFO_CNT_W'(BURST_LEN);

  logic [2:0]                 state_reg;
  logic [CTRL_ADDR_WIDTH-1:0] addr_reg;
  logic [BC_W-1:0]            burst_cnt_reg;
  logic [3:0]                 beat_cnt_reg;
  logic                       vs_pend_reg;
  logic [CTRL_ADDR_WIDTH-1:0] base_addr;
  logic [CTRL_ADDR_WIDTH-1:0] next_base;
  logic                       last_burst;
  logic                       vs_hit;
  logic                       unused_cmd_done;

`ifdef FRAME_PINGPONG_EN
  localparam logic [CTRL_ADDR_WIDTH-1:0] BASE1 =
    BASE0 + CTRL_ADDR_WIDTH'(BURSTS_PER_FRAME * BURST_LEN * 8);
  logic frame_sel_reg;
  assign base_addr    = frame_sel_reg ? BASE1 : BASE0;
  assign next_base    = frame_sel_reg ? BASE0 : BASE1;
  assign wr_frame_sel = frame_sel_reg;
`else
  assign base_addr = BASE0;
  assign next_base = BASE0;
`endif

  // Beat counting is ours; the controller's last-beat flag is not trusted.
  assign unused_cmd_done = wr_cmd_done;

  assign last_burst = (burst_cnt_reg == LAST_BURST);
  assign vs_hit     = vs_pend_reg | vsync;
  assign fifo_rd_en = (state_reg == ST_DATA) & wr_ready;
  assign wr_data    = fifo_rd_data;
  assign busy       = (state_reg != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= BASE0;
      burst_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      vs_pend_reg   <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_id         <= '0;
      wr_len        <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
`ifdef FRAME_PINGPONG_EN
      frame_sel_reg <= 1'b0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (vsync) begin
            addr_reg      <= base_addr;
            burst_cnt_reg <= '0;
            vs_pend_reg   <= 1'b0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A fresh vsync restarts the frame; only a partially written frame is an error.
          if (vsync) begin
            addr_reg      <= base_addr;
            burst_cnt_reg <= '0;
            frame_err     <= (burst_cnt_reg != '0);
          end else if (fifo_rd_cnt >= BURST_WORDS) begin
            wr_en     <= 1'b1;
            wr_addr   <= addr_reg;
            wr_len    <= LAST_BEAT;
            wr_id     <= WR_ID;
            state_reg <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (vsync) vs_pend_reg <= 1'b1;
          state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (vsync) vs_pend_reg <= 1'b1;
          if (wr_ready) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= ST_NEXT;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
          end
        end
        ST_NEXT: begin
          vs_pend_reg <= 1'b0;
          if (last_burst) begin
            // Completed frame: frame_done wins over a pending vsync, which just re-arms.
            frame_done    <= 1'b1;
            addr_reg      <= next_base;
            burst_cnt_reg <= '0;
`ifdef FRAME_PINGPONG_EN
            frame_sel_reg <= ~frame_sel_reg;
`endif
            state_reg     <= vs_hit ? ST_WAIT : ST_IDLE;
          end else if (vs_hit) begin
            frame_err     <= 1'b1;
            addr_reg      <= base_addr;
            burst_cnt_reg <= '0;
            state_reg     <= ST_WAIT;
          end else begin
            addr_reg      <= addr_reg + STEP;
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
            state_reg     <= ST_WAIT;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
